// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the TTT connection network and the token
// accumulator: the 3-bit network instruction codes and the accumulator state
// encoding.
// ----------------------------------------------------------------------------
package ttt_pkg;

    // Instruction codes understood by the connection network.
    typedef enum logic [2:0] {
        INSTR_NOP         = 3'b000,
        INSTR_RESERVED    = 3'b001,
        INSTR_LOAD        = 3'b010,
        INSTR_ITER        = 3'b011,
        INSTR_PROG_GOOD   = 3'b100,
        INSTR_PROG_BAD    = 3'b101,
        INSTR_PROG_INDPTR = 3'b110,
        INSTR_PROG_INDEX  = 3'b111
    } instr_e;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2
    } acc_state_e;

endpackage

// File: rtl/ttt_token_accumulator_if.sv
// ----------------------------------------------------------------------------
// ttt_token_accumulator_if
// Link between the token accumulator and the TTT connection network.
//   net_instruction / net_processor_id : accumulator -> network
//   net_valid / net_done               : network stream flags
//   net_target_id                      : target processor of current entry
//   net_new_good_tokens / _bad_tokens  : signed per-connection deltas
// Modports: master = accumulator side, slave = network side.
// ----------------------------------------------------------------------------
interface ttt_token_accumulator_if #(
    parameter int NUM_PROCESSORS = 4,
    parameter int NEW_TOKEN_BITS = 4
);
    localparam int ID_W  = $clog2(NUM_PROCESSORS + 1);
    localparam int TGT_W = $clog2(NUM_PROCESSORS);

    logic [2:0]                       net_instruction;
    logic [ID_W-1:0]                  net_processor_id;
    logic                             net_valid;
    logic                             net_done;
    logic [TGT_W-1:0]                 net_target_id;
    logic signed [NEW_TOKEN_BITS-1:0] net_new_good_tokens;
    logic signed [NEW_TOKEN_BITS-1:0] net_new_bad_tokens;

    modport master (
        output net_instruction, net_processor_id,
        input  net_valid, net_done, net_target_id,
               net_new_good_tokens, net_new_bad_tokens
    );

    modport slave (
        input  net_instruction, net_processor_id,
        output net_valid, net_done, net_target_id,
               net_new_good_tokens, net_new_bad_tokens
    );
endinterface

// File: rtl/ttt_sat_add.sv
// ----------------------------------------------------------------------------
// ttt_sat_add
// Combinational signed saturating adder: o_sum = clamp(i_acc + i_delta) to
// the ACC_BITS signed range. IN_BITS must not exceed ACC_BITS.
//   i_acc   : ACC_BITS signed accumulator value
//   i_delta : IN_BITS signed increment (sign-extended)
//   o_sum   : ACC_BITS signed saturated result
// ----------------------------------------------------------------------------
module ttt_sat_add #(
    parameter int IN_BITS  = 4,
    parameter int ACC_BITS = 8
) (
    input  logic signed [ACC_BITS-1:0] i_acc,
    input  logic signed [IN_BITS-1:0]  i_delta,
    output logic signed [ACC_BITS-1:0] o_sum
);
    localparam int SUM_W = ACC_BITS + 1;

    logic signed [SUM_W-1:0] w_sum;

    // One guard bit is enough: |delta| never exceeds the accumulator range.
    assign w_sum = SUM_W'(i_acc) + SUM_W'(i_delta);

    always_comb begin
        o_sum = w_sum[ACC_BITS-1:0];
        // Guard bit disagreeing with the result sign bit means overflow;
        // the guard bit gives the true sign of the sum.
        if (w_sum[ACC_BITS] != w_sum[ACC_BITS-1]) begin
            o_sum = w_sum[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}}
                                    : {1'b0, {(ACC_BITS-1){1'b1}}};
        end
    end
endmodule

// File: rtl/ttt_token_accumulator.sv
// ----------------------------------------------------------------------------
// ttt_token_accumulator
// Runs the network's LOAD/ITER sequence for one source processor and adds the
// returned signed good/bad deltas into per-processor saturating counters.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, source_id    : begin a run (IDLE, prog_en=0, id in range)
//   clear               : zero all counters (IDLE only)
//   prog_en/_instruction/_processor_id : forwarded to the network in IDLE
//   net (master)        : network instruction out, entry stream in
//   rd_id, rd_good, rd_bad : combinational counter read port
//   busy, finished, conn_count : run status
// ----------------------------------------------------------------------------
module ttt_token_accumulator
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 4,
    parameter int NEW_TOKEN_BITS = 4,
    parameter int TOKEN_BITS     = 8,
    localparam int ID_W  = $clog2(NUM_PROCESSORS + 1),
    localparam int TGT_W = $clog2(NUM_PROCESSORS),
    localparam int CNT_W = $clog2(NUM_PROCESSORS * NUM_PROCESSORS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ID_W-1:0]              source_id,
    input  logic                         clear,
    input  logic                         prog_en,
    input  logic [2:0]                   prog_instruction,
    input  logic [ID_W-1:0]              prog_processor_id,
    ttt_token_accumulator_if.master      net,
    input  logic [TGT_W-1:0]             rd_id,
    output logic signed [TOKEN_BITS-1:0] rd_good,
    output logic signed [TOKEN_BITS-1:0] rd_bad,
    output logic                         busy,
    output logic                         finished,
    output logic [CNT_W-1:0]             conn_count
);
    acc_state_e                   r_state;
    acc_state_e                   w_state_next;
    logic [ID_W-1:0]              r_source;
    logic [CNT_W-1:0]             r_conn_count;
    logic                         r_finished;
    logic signed [TOKEN_BITS-1:0] r_good [NUM_PROCESSORS];
    logic signed [TOKEN_BITS-1:0] r_bad  [NUM_PROCESSORS];

    logic                         w_start_ok;
    logic                         w_clear_now;
    logic                         w_acc_en;
    logic [NUM_PROCESSORS-1:0]    w_wr_en;
    logic [2:0]                   w_net_instr;
    logic [ID_W-1:0]              w_net_pid;
    logic signed [TOKEN_BITS-1:0] w_good_sum;
    logic signed [TOKEN_BITS-1:0] w_bad_sum;

    assign w_start_ok  = (r_state == IDLE) && start && !prog_en &&
                         (int'(source_id) < NUM_PROCESSORS);
    assign w_clear_now = (r_state == IDLE) && clear;
    // done has priority over valid; out-of-range targets are dropped.
    assign w_acc_en    = (r_state == ITER) && net.net_valid && !net.net_done &&
                         (int'(net.net_target_id) < NUM_PROCESSORS);

    // Per-entry write enables decoded from the target id.
    for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_wr_en
        assign w_wr_en[gi] = w_acc_en && (net.net_target_id == TGT_W'(gi));
    end

    ttt_sat_add #(.IN_BITS(NEW_TOKEN_BITS), .ACC_BITS(TOKEN_BITS)) u_sat_good (
        .i_acc   (r_good[net.net_target_id]),
        .i_delta (net.net_new_good_tokens),
        .o_sum   (w_good_sum)
    );

    ttt_sat_add #(.IN_BITS(NEW_TOKEN_BITS), .ACC_BITS(TOKEN_BITS)) u_sat_bad (
        .i_acc   (r_bad[net.net_target_id]),
        .i_delta (net.net_new_bad_tokens),
        .o_sum   (w_bad_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_net_instr  = INSTR_NOP;
        w_net_pid    = '0;
        case (r_state)
            IDLE: begin
                if (prog_en) begin
                    w_net_instr = prog_instruction;
                    w_net_pid   = prog_processor_id;
                end
                if (w_start_ok) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_net_instr  = INSTR_LOAD;
                w_net_pid    = r_source;
                w_state_next = ITER;
            end
            ITER: begin
                w_net_instr = INSTR_ITER;
                w_net_pid   = r_source;
                if (net.net_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // The network must see NOP while we are held in reset, even if the
        // programming path is active.
        if (!rst_n) begin
            w_net_instr = INSTR_NOP;
            w_net_pid   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_source     <= '0;
            r_conn_count <= '0;
            r_finished   <= 1'b0;
        end else begin
            r_finished <= (r_state == ITER) && net.net_done;
            if (w_start_ok) begin
                r_source     <= source_id;
                r_conn_count <= '0;
            end else if (w_acc_en) begin
                r_conn_count <= r_conn_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear_now) begin
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                r_good[i] <= '0;
                r_bad[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                if (w_wr_en[i]) begin
                    r_good[i] <= w_good_sum;
                    r_bad[i]  <= w_bad_sum;
                end
            end
        end
    end

    assign net.net_instruction  = w_net_instr;
    assign net.net_processor_id = w_net_pid;
    assign rd_good              = r_good[rd_id];
    assign rd_bad               = r_bad[rd_id];
    assign busy                 = (r_state != IDLE);
    assign finished             = r_finished;
    assign conn_count           = r_conn_count;
endmodule
